gray_updown_counter: RTL
========================

Name: gray_updown_counter

Overview:
Parametrised WIDTH-bit Gray-code up/down counter with synchronous clear, synchronous preset, parallel Gray-code load, enable, and a selectable wrap or saturate mode. It provides the registered Gray count, its registered binary equivalent, and a terminal-count flag for cascading. It is the general-purpose successor to the fixed 4-bit Gray up counter in the macro behaviour library. Typical uses are clock-domain-crossing pointers and low-toggle position counters.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
PRESET, {WIDTH{1'b1}}, Gray-code value loaded by PS.
WRAP, 1, 1 = wrap at terminal count; 0 = saturate at terminal count.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
CD  input  1  reset/clear; synchronous, active-high.
D  input  WIDTH  parallel load value, Gray-coded.
LD  input  1  synchronous parallel load.
EN  input  1  count enable.
PS  input  1  synchronous preset to PRESET.
UP  input  1  direction; 1 = up, 0 = down.
Q  output  WIDTH  Gray-coded count, registered.
QB  output  WIDTH  binary equivalent of Q, registered.
TC  output  1  terminal count; combinational from state, EN and UP.

Behaviour:
- One clock domain, CLK only. Reset is synchronous and active-high on CD; there is no asynchronous path.
- State is a binary register B. Q is registered as the Gray code of B (B ^ (B>>1)). QB is registered equal to B.
- Q and QB update in the same edge, both directly from flops. No combinational glitching on Q.
- Priority at each rising CLK edge: CD > PS > LD > EN > hold.
- CD=1: B <= 0, so Q=0 and QB=0. This is the reset value of all state. TC follows its equation below.
- PS=1 (CD=0): B <= Gray-to-binary(PRESET). Default for WIDTH=4: Q=1111, QB=1010.
- LD=1 (CD=PS=0): B <= Gray-to-binary(D), using the prefix XOR from the MSB (b[i] = ^D[WIDTH-1:i]).
  - Every WIDTH-bit vector is a legal Gray code, so there is no illegal-load case.
  - LD overrides EN and UP in that cycle.
- EN=1 (CD=PS=LD=0):
  - UP=1: B <= B+1 mod 2^WIDTH.
  - UP=0: B <= B-1 mod 2^WIDTH.
- Exactly one bit of Q toggles per count step, in either direction.
- Terminal state:
  - Up: B = 2^WIDTH-1, i.e. Q = 1 followed by WIDTH-1 zeros.
  - Down: B = 0, i.e. Q all zeros.
- WRAP=1: counting past the terminal state wraps (up: max->0; down: 0->max).
- WRAP=0: counting at the terminal state in the current direction holds the value. Counting in the opposite direction proceeds normally.
- TC = EN & (UP ? B==2^WIDTH-1 : B==0).
  - Unaffected by WRAP.
  - TC is not gated by CD, PS or LD; cascaded stages must gate their own EN.
- EN=0 with no other control asserted: hold. Q and QB are unchanged and TC=0.
- Changing UP mid-count takes effect on the next enabled edge; there is no extra latency.
- CD asserted mid-count clears on that same edge, regardless of PS, LD or EN.
- Latency: control-to-Q is one clock. Q-to-TC is combinational.

Test Plan:
- WIDTH=4, CD=1 for one edge, then EN=1, UP=1 for 16 edges -> Q sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. QB counts 0..15,0. TC=1 only while Q=1000.
- WIDTH=4, EN=1, UP=0 from Q=0000 -> TC=1 at Q=0000; next edges give Q=1000, then 1001, then 1011. QB=15,14,13.
- WIDTH=4, WRAP=0, load D=1000 (QB=15), then EN=1, UP=1 for 3 edges -> Q stays 1000, TC=1. Then UP=0 for one edge -> Q=1001, QB=14.
- Priority: assert CD=PS=LD=EN=1 with D=0110 -> Q=0000. Drop CD -> Q=1111, QB=1010. Drop PS -> Q=0110, QB=0100. Drop LD -> Q=0111 next edge.
- Hold: EN=0 for 5 edges from Q=0101 -> Q=0101, QB=0110, TC=0 throughout.
- WIDTH=8, WRAP=1: random run of 2000 cycles with random EN/UP/LD/PS/CD -> checker confirms the priority rules, the binary model match for QB, Q == QB^(QB>>1), and at most one Q bit change per EN-only edge.

Source files
------------

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : gray_updown_counter
// Brief   : WIDTH-bit Gray up/down counter with clear, preset, load, wrap/saturate
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module gray_updown_counter #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] PRESET = {WIDTH{1'b1}},
  parameter bit               WRAP   = 1'b1
) (
  input  logic             CLK,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic             EN,
  input  logic             PS,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             TC
);

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  localparam logic [WIDTH-1:0] C_MAX        = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_PRESET_BIN = f_gray2bin(PRESET);

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_at_top;
  logic             w_at_bot;

  assign w_at_top = (r_b == C_MAX);
  assign w_at_bot = (r_b == '0);

  always_comb begin
    w_next = r_b;
    if (CD) begin
      w_next = '0;
    end else if (PS) begin
      w_next = C_PRESET_BIN;
    end else if (LD) begin
      w_next = f_gray2bin(D);
    end else if (EN) begin
      if (UP) begin
        if (!(w_at_top && !WRAP)) w_next = r_b + 1'b1;
      end else begin
        if (!(w_at_bot && !WRAP)) w_next = r_b - 1'b1;
      end
    end
  end

  // Q is encoded from the next binary value so both outputs leave flops together.
  always_ff @(posedge CLK) begin
    if (CD) begin
      r_b <= '0;
      r_q <= '0;
    end else begin
      r_b <= w_next;
      r_q <= w_next ^ (w_next >> 1);
    end
  end

  assign Q  = r_q;
  assign QB = r_b;
  assign TC = EN & (UP ? w_at_top : w_at_bot);

endmodule
`default_nettype wire
